sprite_line_scheduler: RTL and testbench

Per-scanline sprite evaluator feeding the 8-stage sprite shift chain. During horizontal blanking it clears the chain, then scans the sprite attribute table in video RAM and selects up to 8 sprites that intersect the next scanline. For each one it fetches its palette word and one 32-bit pattern row, then pushes them into the chain with a `shift` pulse. It owns the shared 32-bit video RAM read port (`addr`/`fromRAM`) while scanning.

---
 rtl/sprite_sched_pkg.sv | 59 +++++
 rtl/spr_attr_decode.sv | 39 +++
 rtl/sprite_line_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_sched_pkg.sv
// ---------------------------------------------------------------------------
// sprite_sched_pkg
// Shared definitions for the per-scanline sprite scheduler:
//   - state_t      : scheduler FSM states
//   - *_LSB / *_W  : bit positions of the fields in attribute words 0 and 1
//   - SPR_H        : sprite height in lines
//   - ATTR_WORDS / PAT_WORDS : address strides of the attribute table and
//                    pattern memory
// ---------------------------------------------------------------------------
package sprite_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_A0,
        S_W0,
        S_A1,
        S_W1,
        S_AP,
        S_WP,
        S_SH,
        S_NEXT,
        S_DONE
    } state_t;

    // Attribute word 0
    localparam int POSX_LSB = 0;
    localparam int POSX_W   = 9;
    localparam int POSY_LSB = 9;
    localparam int POSY_W   = 9;
    localparam int SCLX_LSB = 18;
    localparam int SCLX_W   = 4;
    localparam int SWPX_BIT = 22;
    localparam int EN_BIT   = 23;
    localparam int PAT_LSB  = 24;
    localparam int PAT_W    = 5;

    // Attribute word 1
    localparam int BCOL_W    = 5;
    localparam int BCOL1_LSB = 0;
    localparam int BCOL2_LSB = 5;
    localparam int BCOL3_LSB = 10;
    localparam int BCOL4_LSB = 15;

    // Geometry and address strides
    localparam int SPR_H      = 16;
    localparam int ROW_W      = 4;
    localparam int ATTR_WORDS = 2;
    localparam int PAT_WORDS  = 16;
    localparam int IDX_W      = 8;

    // Word address of one half of an attribute entry.
    function automatic logic [15:0] attr_addr(input logic [15:0]      base,
                                              input logic [IDX_W-1:0] idx,
                                              input logic             second);
        return base + {7'd0, idx, second};
    endfunction

endpackage

// File: rtl/spr_attr_decode.sv
// ---------------------------------------------------------------------------
// spr_attr_decode
// Combinational hit test for one sprite against the line being prepared.
// Ports:
//   word0    in  32 : attribute word 0 straight from RAM
//   next_y   in   9 : line being evaluated
//   hit      out  1 : sprite enabled and covers next_y
//   row      out  4 : pattern row selected by next_y
//   pat_addr out 16 : word address of that pattern row
// ---------------------------------------------------------------------------
module spr_attr_decode
    import sprite_sched_pkg::*;
#(
    parameter logic [15:0] PAT_BASE = 16'hE000
) (
    input  logic [31:0] word0,
    input  logic [8:0]  next_y,
    output logic        hit,
    output logic [3:0]  row,
    output logic [15:0] pat_addr
);

    logic [8:0]       dy;
    logic [PAT_W-1:0] pattern;
    logic             unused_bits;

    // dy wraps mod 512, so a sprite near the bottom of the 9-bit space stays
    // visible on the first lines after the wrap.
    always_comb begin
        dy       = next_y - word0[POSY_LSB +: POSY_W];
        pattern  = word0[PAT_LSB +: PAT_W];
        row      = dy[ROW_W-1:0];
        hit      = word0[EN_BIT] && (dy < 9'(SPR_H));
        pat_addr = PAT_BASE + {7'd0, pattern, dy[ROW_W-1:0]};
    end

    assign unused_bits = ^{word0[31:29], word0[SWPX_BIT:SCLX_LSB], word0[POSX_W-1:0]};

endmodule

// File: rtl/sprite_line_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_line_scheduler
// During hblank, clears the 8-stage sprite shift chain, scans the attribute
// table and loads up to MAX_SLOTS sprites that intersect the next line.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   CounterX, CounterY  : beam position; CounterX == START_X starts a scan
//   fromRAM             : RAM read data, valid one clk after addr
//   addr                : registered RAM word address
//   clr / shift         : one-cycle chain clear / chain load strobes
//   posX sclX swpX colors bcol1..bcol4 : fields of the sprite being loaded
//   busy                : scan in progress
//   count / overflow    : sprites loaded this line / more hits than slots
// ---------------------------------------------------------------------------
module sprite_line_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int          NSPR      = 32,
    parameter int          MAX_SLOTS = 8,
    parameter logic [15:0] ATTR_BASE = 16'hF000,
    parameter logic [15:0] PAT_BASE  = 16'hE000,
    parameter logic [9:0]  START_X   = 10'd640,
    parameter logic [8:0]  V_LINES   = 9'd480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  CounterX,
    input  logic [8:0]  CounterY,
    input  logic [31:0] fromRAM,
    output logic [15:0] addr,
    output logic        clr,
    output logic        shift,
    output logic [8:0]  posX,
    output logic [3:0]  sclX,
    output logic        swpX,
    output logic [31:0] colors,
    output logic [4:0]  bcol1,
    output logic [4:0]  bcol2,
    output logic [4:0]  bcol3,
    output logic [4:0]  bcol4,
    output logic        busy,
    output logic [3:0]  count,
    output logic        overflow
);

    localparam logic [3:0]       MAX_CNT  = 4'(MAX_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSPR - 1);

    state_t           state_reg, state_next;
    logic             x_match_reg, x_match_d_reg;
    logic             trigger;
    logic [8:0]       next_y_reg, next_y_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [3:0]       count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic [15:0]      addr_reg, addr_next;
    logic [15:0]      pat_addr_reg, pat_addr_next;
    logic [8:0]       posx_reg, posx_next;
    logic [3:0]       sclx_reg, sclx_next;
    logic             swpx_reg, swpx_next;
    logic [31:0]      colors_reg, colors_next;
    logic [4:0]       bcol1_reg, bcol1_next;
    logic [4:0]       bcol2_reg, bcol2_next;
    logic [4:0]       bcol3_reg, bcol3_next;
    logic [4:0]       bcol4_reg, bcol4_next;

    logic             dec_hit;
    logic [3:0]       dec_row;
    logic [15:0]      dec_pat_addr;
    logic             unused_row;

    // The decoder always looks at the raw RAM word; its result only matters in W0.
    spr_attr_decode #(
        .PAT_BASE (PAT_BASE)
    ) u_decode (
        .word0    (fromRAM),
        .next_y   (next_y_reg),
        .hit      (dec_hit),
        .row      (dec_row),
        .pat_addr (dec_pat_addr)
    );

    assign unused_row = ^dec_row;

    // Holding CounterX at START_X for several clocks still yields one trigger.
    assign trigger = x_match_reg && !x_match_d_reg;

    always_comb begin
        state_next    = state_reg;
        next_y_next   = next_y_reg;
        idx_next      = idx_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        pat_addr_next = pat_addr_reg;
        posx_next     = posx_reg;
        sclx_next     = sclx_reg;
        swpx_next     = swpx_reg;
        colors_next   = colors_reg;
        bcol1_next    = bcol1_reg;
        bcol2_next    = bcol2_reg;
        bcol3_next    = bcol3_reg;
        bcol4_next    = bcol4_reg;
        addr_next     = addr_reg;
        clr           = 1'b0;
        shift         = 1'b0;
        busy          = (state_reg != S_IDLE);

        case (state_reg)
            S_IDLE: begin
                if (trigger) begin
                    next_y_next = (CounterY == V_LINES - 9'd1) ? 9'd0 : CounterY + 9'd1;
                    state_next  = S_CLR;
                end
            end
            S_CLR: begin
                clr           = 1'b1;
                count_next    = 4'd0;
                overflow_next = 1'b0;
                idx_next      = '0;
                state_next    = S_A0;
            end
            S_A0: state_next = S_W0;
            S_W0: begin
                if (dec_hit) begin
                    if (count_reg < MAX_CNT) begin
                        // Geometry fields are only taken for sprites that will be
                        // loaded, so they keep describing the last loaded sprite.
                        posx_next     = fromRAM[POSX_LSB +: POSX_W];
                        sclx_next     = fromRAM[SCLX_LSB +: SCLX_W];
                        swpx_next     = fromRAM[SWPX_BIT];
                        pat_addr_next = dec_pat_addr;
                        state_next    = S_A1;
                    end else begin
                        overflow_next = 1'b1;
                        state_next    = S_DONE;
                    end
                end else begin
                    state_next = S_NEXT;
                end
            end
            S_A1: state_next = S_W1;
            S_W1: begin
                bcol1_next = fromRAM[BCOL1_LSB +: BCOL_W];
                bcol2_next = fromRAM[BCOL2_LSB +: BCOL_W];
                bcol3_next = fromRAM[BCOL3_LSB +: BCOL_W];
                bcol4_next = fromRAM[BCOL4_LSB +: BCOL_W];
                state_next = S_AP;
            end
            S_AP: state_next = S_WP;
            S_WP: begin
                colors_next = fromRAM;
                state_next  = S_SH;
            end
            S_SH: begin
                shift      = 1'b1;
                count_next = count_reg + 4'd1;
                state_next = S_NEXT;
            end
            S_NEXT: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = S_DONE;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = S_A0;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // The address register is loaded on entry to each address state, so the
        // address is already on the RAM port during A0/A1/AP and the registered
        // read data lands in the following wait state.
        case (state_next)
            S_A0:    addr_next = attr_addr(ATTR_BASE, idx_next, 1'b0);
            S_A1:    addr_next = attr_addr(ATTR_BASE, idx_next, 1'b1);
            S_AP:    addr_next = pat_addr_reg;
            default: addr_next = addr_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            x_match_reg   <= 1'b0;
            x_match_d_reg <= 1'b0;
            next_y_reg    <= '0;
            idx_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            addr_reg      <= '0;
            pat_addr_reg  <= '0;
            posx_reg      <= '0;
            sclx_reg      <= '0;
            swpx_reg      <= 1'b0;
            colors_reg    <= '0;
            bcol1_reg     <= '0;
            bcol2_reg     <= '0;
            bcol3_reg     <= '0;
            bcol4_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            x_match_reg   <= (CounterX == START_X);
            x_match_d_reg <= x_match_reg;
            next_y_reg    <= next_y_next;
            idx_reg       <= idx_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            addr_reg      <= addr_next;
            pat_addr_reg  <= pat_addr_next;
            posx_reg      <= posx_next;
            sclx_reg      <= sclx_next;
            swpx_reg      <= swpx_next;
            colors_reg    <= colors_next;
            bcol1_reg     <= bcol1_next;
            bcol2_reg     <= bcol2_next;
            bcol3_reg     <= bcol3_next;
            bcol4_reg     <= bcol4_next;
        end
    end

    assign addr     = addr_reg;
    assign posX     = posx_reg;
    assign sclX     = sclx_reg;
    assign swpX     = swpx_reg;
    assign colors   = colors_reg;
    assign bcol1    = bcol1_reg;
    assign bcol2    = bcol2_reg;
    assign bcol3    = bcol3_reg;
    assign bcol4    = bcol4_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sprite_line_scheduler
// Directed bench: a registered-read RAM model holds the attribute table and
// a pattern area whose words encode their own offset (32'hC0DE0000 | off),
// so every loaded pattern row can be identified by value.
// ---------------------------------------------------------------------------
module tb_sprite_line_scheduler;

    localparam logic [15:0] ATTR_B = 16'hF000;
    localparam logic [15:0] PAT_B  = 16'hE000;
    localparam logic [9:0]  SX     = 10'd640;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  CounterX;
    logic [8:0]  CounterY;
    logic [31:0] fromRAM;
    logic [15:0] addr;
    logic        clr, shift, swpX, busy, overflow;
    logic [8:0]  posX;
    logic [3:0]  sclX, count;
    logic [31:0] colors;
    logic [4:0]  bcol1, bcol2, bcol3, bcol4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sprite_line_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .CounterX (CounterX),
        .CounterY (CounterY),
        .fromRAM  (fromRAM),
        .addr     (addr),
        .clr      (clr),
        .shift    (shift),
        .posX     (posX),
        .sclX     (sclX),
        .swpX     (swpX),
        .colors   (colors),
        .bcol1    (bcol1),
        .bcol2    (bcol2),
        .bcol3    (bcol3),
        .bcol4    (bcol4),
        .busy     (busy),
        .count    (count),
        .overflow (overflow)
    );

    // RAM model: registered read
    logic [31:0] mem [0:65535];
    always @(posedge clk) fromRAM <= mem[addr];

    // Monitor: records every shift and every attribute address presented
    logic [8:0]  sh_posx   [0:15];
    logic [3:0]  sh_sclx   [0:15];
    logic        sh_swpx   [0:15];
    logic [31:0] sh_colors [0:15];
    logic [4:0]  sh_b1     [0:15];
    logic [4:0]  sh_b4     [0:15];
    int          sh_n      = 0;
    int          clr_cnt   = 0;
    int          both_cnt  = 0;
    logic [63:0] attr_seen = '0;
    logic [15:0] aoff;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (clr) clr_cnt++;
            if (clr && shift) both_cnt++;
            if (shift && sh_n < 16) begin
                sh_posx[sh_n]   = posX;
                sh_sclx[sh_n]   = sclX;
                sh_swpx[sh_n]   = swpX;
                sh_colors[sh_n] = colors;
                sh_b1[sh_n]     = bcol1;
                sh_b4[sh_n]     = bcol4;
            end
            if (shift) sh_n++;
            aoff = addr - ATTR_B;
            if (addr >= ATTR_B && aoff < 16'd64) attr_seen[aoff[5:0]] = 1'b1;
        end
    end

    function automatic logic [31:0] mk_w0(input logic [8:0] px, input logic [8:0] py,
                                          input logic [3:0] sx, input logic sw,
                                          input logic en, input logic [4:0] pat);
        return {3'b000, pat, en, sw, sx, py, px};
    endfunction

    function automatic logic [31:0] mk_w1(input logic [4:0] b1, input logic [4:0] b2,
                                          input logic [4:0] b3, input logic [4:0] b4);
        return {12'h000, b4, b3, b2, b1};
    endfunction

    function automatic logic [31:0] pat_word(input int off);
        return 32'hC0DE_0000 | 32'(off);
    endfunction

    task automatic clear_attr();
        for (int k = 0; k < 64; k++) mem[ATTR_B + 16'(k)] = 32'h0;
    endtask

    task automatic clear_mon();
        sh_n      = 0;
        clr_cnt   = 0;
        attr_seen = '0;
    endtask

    // One scan: trigger on line cy, CounterX held at START_X for 'hold' clocks,
    // optional second pulse while busy. Waits (bounded) for busy to drop.
    task automatic run_scan(input logic [8:0] cy, input int hold, input bit retrig,
                            output int busy_cyc, output int clr_lat, output bit timeout);
        int cyc;
        bit seen_busy;
        @(posedge clk); #1;
        clear_mon();
        CounterY = cy;
        @(negedge clk);
        CounterX  = SX;
        cyc       = 0;
        seen_busy = 0;
        busy_cyc  = 0;
        clr_lat   = -1;
        timeout   = 1'b1;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == hold) CounterX = 10'd0;
            if (retrig && cyc == 20) CounterX = SX;
            if (retrig && cyc == 22) CounterX = 10'd0;
            if (clr && clr_lat < 0) clr_lat = cyc;
            if (busy) begin
                seen_busy = 1;
                busy_cyc++;
            end else if (seen_busy) begin
                timeout = 1'b0;
                break;
            end
        end
        $display("scan line=%0d shifts=%0d clr=%0d count=%0d overflow=%0d busy_cycles=%0d",
                 cy, sh_n, clr_cnt, count, overflow, busy_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        CounterX = 10'd0;
        CounterY = 9'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", addr); end
        n_checks++; if (clr !== 1'b0 || shift !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got clr=%b shift=%b expected 0 0", clr, shift); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (count !== 4'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_count: got count=%0d ovf=%b expected 0 0", count, overflow); end
        n_checks++; if ({posX, sclX, swpX} !== 14'd0 || colors !== 32'd0) begin n_fail++; $display("FAIL reset_fields: got posX=%0d sclX=%0d swpX=%b colors=%h expected zeros", posX, sclX, swpX, colors); end
        n_checks++; if ({bcol1, bcol2, bcol3, bcol4} !== 20'd0) begin n_fail++; $display("FAIL reset_bcol: got %h expected 0", {bcol1, bcol2, bcol3, bcol4}); end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_single_hit();
        int bc, lat;
        bit to;
        clear_attr();
        mem[ATTR_B + 16'd6] = mk_w0(9'd100, 9'd50, 4'd5, 1'b1, 1'b1, 5'd2);
        mem[ATTR_B + 16'd7] = mk_w1(5'd1, 5'd2, 5'd3, 5'd4);
        run_scan(9'd49, 1, 1'b0, bc, lat, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got timeout=%b expected 0", to); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL single_clr_latency: got %0d expected 2", lat); end
        n_checks++; if (clr_cnt !== 1 || sh_n !== 1) begin n_fail++; $display("FAIL single_pulses: got clr=%0d shift=%0d expected 1 1", clr_cnt, sh_n); end
        if (sh_n >= 1) begin
            n_checks++; if (sh_posx[0] !== 9'd100 || sh_sclx[0] !== 4'd5 || sh_swpx[0] !== 1'b1) begin n_fail++; $display("FAIL single_geom: got posX=%0d sclX=%0d swpX=%b expected 100 5 1", sh_posx[0], sh_sclx[0], sh_swpx[0]); end
            n_checks++; if (sh_colors[0] !== pat_word(32)) begin n_fail++; $display("FAIL single_colors: got %h expected %h", sh_colors[0], pat_word(32)); end
            n_checks++; if (sh_b1[0] !== 5'd1 || sh_b4[0] !== 5'd4) begin n_fail++; $display("FAIL single_bcol: got b1=%0d b4=%0d expected 1 4", sh_b1[0], sh_b4[0]); end
        end
        n_checks++; if (count !== 4'd1 || overflow !== 1'b0) begin n_fail++; $display("FAIL single_count: got count=%0d ovf=%b expected 1 0", count, overflow); end
        // 1 CLR + 31 misses*3 + 1 hit*8 + 1 DONE
        n_checks++; if (bc !== 103) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected 103", bc); end
    endtask

    task automatic test_overflow();
        int bc, lat;
        bit to;
        clear_attr();
        for (int i = 0; i < 10; i++) begin
            mem[ATTR_B + 16'(2*i)]     = mk_w0(9'(10 + i), 9'd10, 4'd0, 1'b0, 1'b1, 5'(i));
            mem[ATTR_B + 16'(2*i + 1)] = mk_w1(5'(i), 5'd0, 5'd0, 5'd0);
        end
        run_scan(9'd12, 1, 1'b0, bc, lat, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL ovf_timeout: got timeout=%b expected 0", to); end
        n_checks++; if (sh_n !== 8) begin n_fail++; $display("FAIL ovf_shifts: got %0d expected 8", sh_n); end
        n_checks++; if (count !== 4'd8 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flags: got count=%0d ovf=%b expected 8 1", count, overflow); end
        if (sh_n >= 8) begin
            n_checks++; if (sh_posx[0] !== 9'd10 || sh_colors[0] !== pat_word(3)) begin n_fail++; $display("FAIL ovf_first: got posX=%0d colors=%h expected 10 %h", sh_posx[0], sh_colors[0], pat_word(3)); end
            n_checks++; if (sh_posx[7] !== 9'd17 || sh_colors[7] !== pat_word(115) || sh_b1[7] !== 5'd7) begin n_fail++; $display("FAIL ovf_last: got posX=%0d colors=%h b1=%0d expected 17 %h 7", sh_posx[7], sh_colors[7], sh_b1[7], pat_word(115)); end
        end
        n_checks++; if (attr_seen[19:17] !== 3'b000) begin n_fail++; $display("FAIL ovf_not_read: got seen[19:17]=%b expected 000", attr_seen[19:17]); end
        // 1 CLR + 8 hits*8 + A0/W0 of entry 8 + DONE
        n_checks++; if (bc !== 68) begin n_fail++; $display("FAIL ovf_busy_cycles: got %0d expected 68", bc); end
    endtask

    task automatic test_row_boundary();
        int bc, lat;
        bit to;
        clear_attr();
        mem[ATTR_B + 16'd4] = mk_w0(9'd300, 9'd20, 4'd1, 1'b0, 1'b1, 5'd3);
        mem[ATTR_B + 16'd5] = mk_w1(5'd9, 5'd0, 5'd0, 5'd31);
        run_scan(9'd34, 1, 1'b0, bc, lat, to);
        n_checks++; if (to !== 1'b0 || sh_n !== 1) begin n_fail++; $display("FAIL row15_shift: got shifts=%0d timeout=%b expected 1 0", sh_n, to); end
        n_checks++; if (overflow !== 1'b0 || count !== 4'd1) begin n_fail++; $display("FAIL row15_flags: got count=%0d ovf=%b expected 1 0", count, overflow); end
        if (sh_n >= 1) begin
            n_checks++; if (sh_colors[0] !== pat_word(63) || sh_b4[0] !== 5'd31) begin n_fail++; $display("FAIL row15_colors: got %h b4=%0d expected %h 31", sh_colors[0], sh_b4[0], pat_word(63)); end
        end
        run_scan(9'd35, 1, 1'b0, bc, lat, to);
        n_checks++; if (to !== 1'b0 || sh_n !== 0 || count !== 4'd0) begin n_fail++; $display("FAIL row16_miss: got shifts=%0d count=%0d expected 0 0", sh_n, count); end
        n_checks++; if (bc !== 98) begin n_fail++; $display("FAIL miss_busy_cycles: got %0d expected 98", bc); end
    endtask

    task automatic test_wrap();
        int bc, lat;
        bit to;
        clear_attr();
        mem[ATTR_B + 16'd0]  = mk_w0(9'd1, 9'd0, 4'd0, 1'b0, 1'b1, 5'd1);
        mem[ATTR_B + 16'd10] = mk_w0(9'd200, 9'd500, 4'd0, 1'b0, 1'b1, 5'd4);
        mem[ATTR_B + 16'd12] = mk_w0(9'd7, 9'd470, 4'd0, 1'b0, 1'b1, 5'd5);
        mem[ATTR_B + 16'd14] = mk_w0(9'd8, 9'd0, 4'd0, 1'b0, 1'b0, 5'd6);
        run_scan(9'd479, 1, 1'b0, bc, lat, to);
        n_checks++; if (to !== 1'b0 || sh_n !== 2) begin n_fail++; $display("FAIL wrap_shifts: got %0d expected 2", sh_n); end
        if (sh_n >= 2) begin
            n_checks++; if (sh_posx[0] !== 9'd1 || sh_colors[0] !== pat_word(16)) begin n_fail++; $display("FAIL wrap_row0: got posX=%0d colors=%h expected 1 %h", sh_posx[0], sh_colors[0], pat_word(16)); end
            n_checks++; if (sh_posx[1] !== 9'd200 || sh_colors[1] !== pat_word(76)) begin n_fail++; $display("FAIL wrap_row12: got posX=%0d colors=%h expected 200 %h", sh_posx[1], sh_colors[1], pat_word(76)); end
        end
        n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL wrap_count: got %0d expected 2", count); end
    endtask

    task automatic test_reset_mid_scan();
        int bc, lat;
        bit to;
        bit found;
        clear_attr();
        mem[ATTR_B + 16'd0] = mk_w0(9'd77, 9'd50, 4'd2, 1'b1, 1'b1, 5'd0);
        mem[ATTR_B + 16'd1] = mk_w1(5'd5, 5'd6, 5'd7, 5'd8);
        @(posedge clk); #1;
        clear_mon();
        CounterY = 9'd49;
        @(negedge clk); CounterX = SX;
        @(negedge clk); CounterX = 10'd0;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (addr == ATTR_B + 16'd1) found = 1;
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rst_reach_a1: got found=%b expected 1", found); end
        @(negedge clk);   // W1
        rst = 1'b1;
        @(negedge clk);
        $display("reset applied during W1");
        n_checks++; if (busy !== 1'b0 || addr !== 16'h0) begin n_fail++; $display("FAIL rst_mid_state: got busy=%b addr=%h expected 0 0000", busy, addr); end
        n_checks++; if (posX !== 9'd0 || bcol1 !== 5'd0 || colors !== 32'd0 || count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_fields: got posX=%0d bcol1=%0d colors=%h count=%0d expected zeros", posX, bcol1, colors, count); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (sh_n !== 0 || clr_cnt !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_shift: got shifts=%0d clr=%0d busy=%b expected 0 1 0", sh_n, clr_cnt, busy); end
        run_scan(9'd49, 1, 1'b0, bc, lat, to);
        n_checks++; if (to !== 1'b0 || sh_n !== 1 || bc !== 103) begin n_fail++; $display("FAIL rst_rescan: got shifts=%0d busy_cycles=%0d expected 1 103", sh_n, bc); end
        if (sh_n >= 1) begin
            n_checks++; if (sh_posx[0] !== 9'd77 || sh_b4[0] !== 5'd8) begin n_fail++; $display("FAIL rst_rescan_fields: got posX=%0d b4=%0d expected 77 8", sh_posx[0], sh_b4[0]); end
        end
    endtask

    task automatic test_retrigger();
        int bc, lat;
        bit to;
        int late_busy;
        clear_attr();
        mem[ATTR_B + 16'd6] = mk_w0(9'd100, 9'd50, 4'd5, 1'b1, 1'b1, 5'd2);
        mem[ATTR_B + 16'd7] = mk_w1(5'd1, 5'd2, 5'd3, 5'd4);
        run_scan(9'd49, 4, 1'b1, bc, lat, to);
        n_checks++; if (to !== 1'b0 || clr_cnt !== 1 || sh_n !== 1) begin n_fail++; $display("FAIL retrig_single: got clr=%0d shifts=%0d expected 1 1", clr_cnt, sh_n); end
        n_checks++; if (bc !== 103) begin n_fail++; $display("FAIL retrig_busy_cycles: got %0d expected 103", bc); end
        late_busy = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy) late_busy++;
        end
        n_checks++; if (late_busy !== 0 || clr_cnt !== 1) begin n_fail++; $display("FAIL retrig_ignored: got busy_cycles=%0d clr=%0d expected 0 1", late_busy, clr_cnt); end
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL clr_shift_overlap: got %0d expected 0", both_cnt); end
    endtask

    initial begin
        for (int k = 0; k < 512; k++) mem[PAT_B + 16'(k)] = pat_word(k);
        clear_attr();
        test_reset();
        test_single_hit();
        test_overflow();
        test_row_boundary();
        test_wrap();
        test_reset_mid_scan();
        test_retrigger();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
